// File: rtl/serial_parity_checker_pkg.sv
// serial_parity_pkg: shared state encoding and frame length for the serial parity blocks
package serial_parity_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
  localparam int DEFAULT_DATA_W = 32;
endpackage

// File: rtl/serial_parity_checker_if.sv
// serial_parity_if: serial bit input and valid/ready word output of the parity checker
interface serial_parity_if #(parameter int DATA_W = serial_parity_pkg::DEFAULT_DATA_W) ();
  logic sin;
  logic sin_valid;
  logic sof;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic out_perr;
  logic out_valid;
  logic overrun;
  logic busy;
  modport master (
    output sin, sin_valid, sof, out_ready,
    input  out_data, out_perr, out_valid, overrun, busy
  );
  modport slave (
    input  sin, sin_valid, sof, out_ready,
    output out_data, out_perr, out_valid, overrun, busy
  );
endinterface

// File: rtl/serial_parity_checker_acc.sv
// serial_parity_acc: running XOR over a bit stream with a frame-length bit counter
module serial_parity_acc import serial_parity_pkg::*; #(
  parameter int N = DEFAULT_DATA_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic step_i,
  input  logic bit_i,
  output logic acc_o,
  output logic done_o
);
  localparam int CW = $clog2(N + 1);
  logic acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // clear wins, a first bit restarts the count at 1, a step extends it
  always_comb begin
    acc_d  = clr_i ? 1'b0 : load_i ? bit_i : step_i ? acc_q ^ bit_i : acc_q;
    cnt_d  = clr_i ? '0 : load_i ? CW'(1) : step_i ? cnt_q + CW'(1) : cnt_q;
    done_o = step_i && !load_i && !clr_i && cnt_q == CW'(N - 1);
  end
  // parity and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: deserialises LSB-first frames and flags parity mismatches
module serial_parity_checker import serial_parity_pkg::*; #(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic clk,
  input logic rst_n,
  serial_parity_if.slave bus
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] sh_q, data_q;
  logic perr_q, valid_q, ovr_q, busy_q;
  logic first, step, fin, accept, acc, done;
  // classify the incoming bit; sof restarts a frame anywhere except on the parity bit
  always_comb begin
    first   = bus.sin_valid && bus.sof && state_q != PAR;
    step    = bus.sin_valid && !bus.sof && state_q == DATA;
    fin     = bus.sin_valid && state_q == PAR;
    accept  = fin && (!valid_q || bus.out_ready);
    state_d = first ? DATA : done ? PAR : fin ? IDLE : state_q;
  end
  serial_parity_acc #(.N(DATA_W)) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (fin),
    .load_i (first),
    .step_i (step),
    .bit_i  (bus.sin),
    .acc_o  (acc),
    .done_o (done)
  );
  // FSM, shift-in from the top so bit 0 ends up as the first bit, and the output holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d != IDLE;
      if (first || step) sh_q <= {bus.sin, sh_q[DATA_W-1:1]};
      if (accept) begin
        data_q <= sh_q;
        perr_q <= acc ^ bus.sin ^ PARITY_ODD;
      end
      valid_q <= accept || (valid_q && !bus.out_ready);
      ovr_q   <= fin && !accept;
    end
  end
  assign bus.out_data  = data_q;
  assign bus.out_perr  = perr_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: random and directed frames against a frame-level reference model
module tb_serial_parity_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  serial_parity_if #(.DATA_W(32)) b0 ();
  serial_parity_if #(.DATA_W(32)) b1 ();
  serial_parity_checker #(.DATA_W(32), .PARITY_ODD(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  serial_parity_checker #(.DATA_W(32), .PARITY_ODD(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 0;
  logic [31:0] cur_word, m_data;
  logic cur_p, m_valid, m_perr0, m_perr1, m_busy, m_ovr;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  task automatic drive(input logic v, input logic s, input logic f, input logic r);
    b0.sin_valid = v; b0.sin = s; b0.sof = f; b0.out_ready = r;
    b1.sin_valid = v; b1.sin = s; b1.sof = f; b1.out_ready = r;
  endtask
  task automatic check_all();
    check("valid_even", 32'(b0.out_valid), 32'(m_valid));
    check("data_even", b0.out_data, m_data);
    check("perr_even", 32'(b0.out_perr), 32'(m_perr0));
    check("overrun_even", 32'(b0.overrun), 32'(m_ovr));
    check("busy_even", 32'(b0.busy), 32'(m_busy));
    check("valid_odd", 32'(b1.out_valid), 32'(m_valid));
    check("data_odd", b1.out_data, m_data);
    check("perr_odd", 32'(b1.out_perr), 32'(m_perr1));
    check("overrun_odd", 32'(b1.overrun), 32'(m_ovr));
    check("busy_odd", 32'(b1.busy), 32'(m_busy));
  endtask
  task automatic model_reset();
    m_valid = 0; m_data = '0; m_perr0 = 0; m_perr1 = 0; m_busy = 0; m_ovr = 0;
  endtask
  task automatic tick(input logic v, input logic s, input logic f, input logic par);
    logic r, take;
    r = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 :
        (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : par;
    drive(v, s, f, r);
    @(posedge clk);
    take = par && (!m_valid || r);
    m_ovr = par && !take;
    m_valid = take || (m_valid && !r);
    if (take) begin
      m_data  = cur_word;
      m_perr0 = (^cur_word) ^ cur_p;
      m_perr1 = (^cur_word) ^ cur_p ^ 1'b1;
    end
    if (v && f) m_busy = 1;
    if (par) m_busy = 0;
    #1;
    check_all();
  endtask
  task automatic gap(input int gmax);
    repeat ($urandom_range(0, gmax)) tick(1'b0, 1'($urandom), 1'($urandom), 1'b0);
  endtask
  task automatic idle(input int n, input logic noise);
    repeat (n) tick(noise && 1'($urandom), 1'($urandom), 1'b0, 1'b0);
  endtask
  task automatic send_bits(input logic [31:0] w, input int n, input int gmax);
    for (int i = 0; i < n; i++) begin
      gap(gmax);
      tick(1'b1, w[i], i == 0, 1'b0);
    end
  endtask
  task automatic send_frame(input logic [31:0] w, input logic p, input int gmax);
    cur_word = w;
    cur_p = p;
    send_bits(w, 32, gmax);
    gap(gmax);
    tick(1'b1, p, 1'b0, 1'b1);
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    cur_word = '0;
    cur_p = 0;
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    send_frame(32'hA5A50001, 1'b1, 0);
    idle(2, 1'b0);
    send_frame(32'hA5A50001, 1'b0, 0);
    idle(2, 1'b1);
    send_frame(32'h00000003, 1'b1, 0);
    send_frame(32'h00000003, 1'b0, 0);
    idle(2, 1'b0);
    rdy_mode = 0;
    send_frame(32'h11111111, 1'b0, 0);
    send_frame(32'h22222222, 1'b0, 0);
    idle(3, 1'b0);
    rdy_mode = 1;
    idle(2, 1'b0);
    rdy_mode = 0;
    send_frame(32'h11111111, 1'b0, 0);
    rdy_mode = 3;
    send_frame(32'h22222222, 1'b0, 0);
    rdy_mode = 1;
    idle(2, 1'b0);
    send_bits(32'hDEADBEEF, 10, 0);
    send_frame(32'h0F0F1234, 1'b1, 0);
    idle(2, 1'b0);
    send_bits(32'hCAFEF00D, 15, 0);
    do_reset();
    send_frame(32'h600DF00D, 1'b0, 0);
    idle(2, 1'b0);
    send_frame(32'hA5A50001, 1'b1, 5);
    idle(2, 1'b0);
    rdy_mode = 2;
    repeat (25) begin
      send_frame($urandom, 1'($urandom_range(0, 1)), 5);
      idle($urandom_range(0, 3), 1'b1);
    end
    rdy_mode = 1;
    idle(3, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
